// File: rtl/exe_div_stage_if.sv
// ID/EXE/MEM handshake, pipeline buses and data SRAM request of the execute stage.
// The stage itself uses the slave modport; the surrounding pipeline uses master.
interface exe_div_stage_if;
    logic [160:0] ID_to_EXE_BUS;
    logic         ID_to_EXE_valid;
    logic         EXE_allowin;
    logic         MEM_allowin;
    logic         EXE_to_MEM_valid;
    logic [108:0] EXE_to_MEM_BUS;
    logic [38:0]  EXE_RF_BUS;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [1:0]   div_state_dbg;

    // Handshake: a transfer happens on a rising edge where the producer's
    // valid and the consumer's allowin are both high.
    modport master (
        output ID_to_EXE_BUS, ID_to_EXE_valid, MEM_allowin,
        input  EXE_allowin, EXE_to_MEM_valid, EXE_to_MEM_BUS, EXE_RF_BUS,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, div_state_dbg
    );

    modport slave (
        input  ID_to_EXE_BUS, ID_to_EXE_valid, MEM_allowin,
        output EXE_allowin, EXE_to_MEM_valid, EXE_to_MEM_BUS, EXE_RF_BUS,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, div_state_dbg
    );
endinterface

// File: rtl/exe_div_stage.sv
// LoongArch-32 execute stage: single-cycle ALU, data SRAM request, 32-step radix-2 divider.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module exe_div_stage (
    input  logic             clk,
    input  logic             resetn,
    exe_div_stage_if.slave   bus
);
    typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_t;

    logic         exe_valid;
    logic [160:0] bus_q;
    logic [31:0]  pc, src1, src2, st_data;
    logic [11:0]  alu_op;
    logic         gr_we, mem_en, mem_we, rfrom_mem;
    logic [4:0]   dest, load_op;
    logic [2:0]   st_op;
    logic [3:0]   div_op;

    assign {pc, alu_op, src1, src2, gr_we, dest, mem_en, mem_we, st_op,
            load_op, rfrom_mem, st_data, div_op} = bus_q;

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_q, div_r, div_b;
    logic        q_neg, r_neg;

    logic exe_ready_go, exe_allowin;
    assign exe_ready_go = (div_op == 4'd0) | (div_state == DIV_DONE);
    assign exe_allowin  = !exe_valid | (exe_ready_go & bus.MEM_allowin);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exe_valid <= 1'b0;
            bus_q     <= '0;
        end else if (exe_allowin) begin
            exe_valid <= bus.ID_to_EXE_valid;
            if (bus.ID_to_EXE_valid) bus_q <= bus.ID_to_EXE_BUS;
        end
    end

    logic [31:0] sum, alu_result;
    assign sum = src1 + src2;

    always_comb begin
        alu_result = ({32{alu_op[11]}} & sum)
                   | ({32{alu_op[10]}} & (src1 - src2))
                   | ({32{alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & (src1 << src2[4:0]))
                   | ({32{alu_op[2]}}  & (src1 >> src2[4:0]))
                   | ({32{alu_op[1]}}  & 32'($signed(src1) >>> src2[4:0]))
                   | ({32{alu_op[0]}}  & src2);
    end

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] div_t, div_sub;
    logic        div_ge;
    assign is_signed = div_op[3] | div_op[2];
    assign a_mag     = (is_signed & src1[31]) ? -src1 : src1;
    assign b_mag     = (is_signed & src2[31]) ? -src2 : src2;
    // Restoring step: the partial remainder always stays below the divisor,
    // so one extra bit is enough to detect the borrow.
    assign div_t     = {div_r, div_q[31]};
    assign div_sub   = div_t - {1'b0, div_b};
    assign div_ge    = !div_sub[32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state <= DIV_IDLE;
            div_cnt   <= 5'd0;
            div_q     <= 32'd0;
            div_r     <= 32'd0;
            div_b     <= 32'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (exe_valid && div_op != 4'd0) begin
                        div_q     <= a_mag;
                        div_b     <= b_mag;
                        div_r     <= 32'd0;
                        div_cnt   <= 5'd0;
                        q_neg     <= is_signed & (src1[31] ^ src2[31]);
                        r_neg     <= is_signed & src1[31];
                        div_state <= DIV_BUSY;
`ifdef DIV_EARLY_OUT_EN
                        if (b_mag != 32'd0 && a_mag < b_mag) begin
                            div_q     <= 32'd0;
                            div_r     <= a_mag;
                            div_state <= DIV_DONE;
                        end
`endif
                    end
                end
                DIV_BUSY: begin
                    div_r   <= div_ge ? div_sub[31:0] : div_t[31:0];
                    div_q   <= {div_q[30:0], div_ge};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) div_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (bus.MEM_allowin) div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    logic        div_zero;
    logic [31:0] div_quot, div_rem, result;
    assign div_zero = (src2 == 32'd0);
    assign div_quot = div_zero ? 32'hFFFF_FFFF : (q_neg ? -div_q : div_q);
    assign div_rem  = div_zero ? src1 : (r_neg ? -div_r : div_r);
    assign result   = (div_op == 4'd0) ? alu_result
                    : ((div_op[2] | div_op[0]) ? div_rem : div_quot);

    logic [3:0]  strobe;
    logic [31:0] wdata;
    always_comb begin
        strobe = 4'b0000;
        wdata  = st_data;
        if (st_op[2]) begin
            strobe = 4'b0001 << sum[1:0];
            wdata  = {4{st_data[7:0]}};
        end else if (st_op[1]) begin
            strobe = sum[1] ? 4'b1100 : 4'b0011;
            wdata  = {2{st_data[15:0]}};
        end else if (st_op[0]) begin
            strobe = 4'b1111;
        end
    end

    assign bus.EXE_allowin      = exe_allowin;
    assign bus.EXE_to_MEM_valid = exe_valid & exe_ready_go;
    assign bus.data_sram_en     = exe_valid & mem_en & exe_ready_go & bus.MEM_allowin;
    assign bus.data_sram_we     = {4{bus.data_sram_en & mem_we}} & strobe;
    assign bus.data_sram_addr   = sum;
    assign bus.data_sram_wdata  = wdata;
    assign bus.EXE_to_MEM_BUS   = {pc, gr_we, dest, result, sum, mem_en, load_op, rfrom_mem};
    assign bus.EXE_RF_BUS       = {dest & {5{gr_we & exe_valid}}, rfrom_mem, exe_ready_go, result};
    assign bus.div_state_dbg    = div_state;
endmodule

// File: doc/exe_div_stage.md
Name: exe_div_stage

Overview:
- Execute stage of the 5-stage in-order LoongArch-32 pipeline, between the decode stage (ID) and the memory stage (MEM).
- Latches the ID→EXE bus and performs the single-cycle ALU ops.
- Issues the data SRAM request, so read data returns in the cycle MEM holds the instruction.
- Runs a 32-iteration radix-2 divider for div/mod ops, stalling with the valid/allowin handshake until the result is ready.

Parameters:
- None. Datapath is fixed at 32 bits; bus layouts are fixed below.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ID_to_EXE_BUS  in  161  MSB→LSB: {pc[32], alu_op[12], src1[32], src2[32], gr_we, dest[5], mem_en, mem_we, st_op[3]{b,h,w}, load_op[5], rfrom_mem, st_data[32], div_op[4]{div.w,mod.w,div.wu,mod.wu}}
- ID_to_EXE_valid  in  1  ID holds a valid instruction
- EXE_allowin  out  1  EXE can accept this cycle
- MEM_allowin  in  1  MEM can accept this cycle
- EXE_to_MEM_valid  out  1  EXE result valid to MEM
- EXE_to_MEM_BUS  out  109  {pc[32], gr_we, dest[5], result[32], data_addr[32], mem_en, load_op[5], rfrom_mem}
- EXE_RF_BUS  out  39  {dest[5] masked by gr_we&EXE_valid, rfrom_mem, exe_ready_go, result[32]}; forwarding/hazard bus to ID
- data_sram_en  out  1  SRAM access enable
- data_sram_we  out  4  byte write strobes
- data_sram_addr  out  32  byte address = src1+src2
- data_sram_wdata  out  32  store data, replicated per size

Behaviour:
- Handshake:
  - EXE_allowin = !EXE_valid | (exe_ready_go & MEM_allowin).
  - EXE_to_MEM_valid = EXE_valid & exe_ready_go.
  - EXE_valid loads ID_to_EXE_valid whenever EXE_allowin.
  - The bus register loads only on ID_to_EXE_valid & EXE_allowin and holds otherwise.
- Reset values: EXE_valid=0, bus register=0, divider state=IDLE, counter=0.
  - While in reset: EXE_to_MEM_valid=0, EXE_allowin=1, data_sram_en=0, data_sram_we=0, EXE_RF_BUS dest=0.
  - Reset asserted mid-division aborts it immediately; no residual stall after release.
- ALU: alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
  - Shifts use src2[4:0].
  - lui returns src2.
  - All-zero alu_op yields 0.
- exe_ready_go = 1 when div_op==0; otherwise exe_ready_go = (div_state==DONE).
- Divider FSM:
  - IDLE→BUSY when EXE_valid & div_op!=0. In that cycle:
    - latch |src1|, |src2| (for signed ops) and the result signs;
    - clear the remainder and set counter=0.
  - BUSY: one restoring shift-subtract iteration per cycle, MSB first; counter+1. At counter==31 go to DONE.
  - DONE: apply signs. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
    - Hold the result. DONE→IDLE on MEM_allowin (the handoff cycle).
- Divider latency:
  - Instruction enters EXE in cycle E0; BUSY covers E1..E32; DONE in E33.
  - EXE_to_MEM_valid goes high in E33 with no early-out.
- Divide-by-zero: quotient=0xFFFFFFFF, remainder=dividend (raw src1); no exception.
- Signed overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- result = divider output (q for div*, r for mod*) if div_op!=0, else ALU output.
- SRAM request:
  - data_sram_en = EXE_valid & mem_en & exe_ready_go & MEM_allowin.
  - data_sram_we = {4{data_sram_en & mem_we}} & strobe.
  - Strobe by st_op and addr[1:0]:
    - st.b: 4'b0001<<addr[1:0];
    - st.h: addr[1] ? 4'b1100 : 4'b0011;
    - st.w: 4'b1111.
  - wdata: st.b → {4{st_data[7:0]}}; st.h → {2{st_data[15:0]}}; st.w → st_data.
  - Misalignment is not checked.
- data_addr on EXE_to_MEM_BUS equals data_sram_addr; MEM uses data_addr[1:0] for load alignment.
- A new instruction arriving in the same cycle DONE hands off is accepted normally; it starts its own division in the following cycle if it is a div op.

Optional Feature:
- DIV_EARLY_OUT_EN defined: in the IDLE→BUSY cycle, if |dividend| < |divisor| (unsigned magnitudes) and divisor≠0, go straight to DONE.
  - Result: quotient=0, remainder=dividend.
  - Latency: DONE in E1.
- Undefined: every division takes the full 32 BUSY cycles.

Test Plan:
- add: src1=5, src2=7, MEM_allowin=1 → EXE_to_MEM_valid the cycle after entry, result=12; sra 0x80000000 by 4 → 0xF8000000.
- st.b: src1=0x1000, src2=3, st_data=0xAB → en=1, we=4'b1000, addr=0x1003, wdata=0xABABABAB; st.h at addr 0x1002 → we=4'b1100.
- div.w: src1=-7, src2=2 → EXE_allowin=0 during E0..E32, valid in E33, result=0xFFFFFFFD; mod.w → 0xFFFFFFFF.
- div.wu: src1=0x10, src2=0 → q=0xFFFFFFFF; mod.wu → 0x10; div.w 0x80000000 / 0xFFFFFFFF → 0x80000000.
- MEM_allowin=0 for 5 cycles during DONE → result and valid held, data_sram_en=0, no new capture; then handoff with MEM_allowin=1 → IDLE, next ID instruction accepted that cycle.
- Async reset pulsed at E10 of a division → outputs zero immediately, EXE_allowin=1; with DIV_EARLY_OUT_EN, 3/10 → DONE in E1, q=0, r=3.
